// File: rtl/ebus_pkg.sv
// Shared EBUS definitions: function codes, responder FSM states and CONO/CONI bit layout.
// Bit numbers follow PDP-10 order: bit 0 is the MSB of a [0:35] word.
package ebus_pkg;

  typedef enum logic [2:0] {
    CONO  = 3'o0,
    CONI  = 3'o1,
    DATAO = 3'o2,
    DATAI = 3'o3,
    RSVD4 = 3'o4,
    RSVD5 = 3'o5,
    RSVD6 = 3'o6,
    RSVD7 = 3'o7
  } ebus_func_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } resp_state_t;

  localparam int CONO_PIA_MSB      = 33;
  localparam int CONO_PIA_LSB      = 35;
  localparam int CONO_ENA_BIT      = 32;
  localparam int CONO_CLR_DONE_BIT = 23;
  localparam int CONO_SET_BUSY_BIT = 22;
  localparam int CONO_CLR_BUSY_BIT = 21;

  typedef struct packed {
    logic [2:0] pia;
    logic       ena;
    logic       clr_done;
    logic       set_busy;
    logic       clr_busy;
  } cono_cmd_t;

  function automatic logic is_dev_func(input ebus_func_t f);
    return f inside {CONO, CONI, DATAO, DATAI};
  endfunction

  function automatic logic is_read_func(input ebus_func_t f);
    return f inside {CONI, DATAI};
  endfunction

  function automatic logic [0:35] coni_word(input logic [0:17] stat, input logic busy,
                                            input logic done, input logic ena,
                                            input logic [2:0] pia);
    return {stat, 11'b0, busy, done, ena, 1'b0, pia};
  endfunction

  // Channel k request lives in bit k-1; PIA of zero means the device is not on PI.
  function automatic logic [6:0] pi_encode(input logic [2:0] pia, input logic req);
    logic [6:0] r;
    r = '0;
    if (req && (pia != 3'd0)) r[pia - 3'd1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/ebus_io_responder_if.sv
// EBUS signal bundle between the EBOX (master) and a device-side responder (slave).
interface ebus_io_responder_if;
  import ebus_pkg::*;

  logic [6:0]  ebus_cs;
  ebus_func_t  ebus_func;
  logic        ebus_demand;
  logic [0:35] ebus_data_in;
  logic        ebus_xfer;
  logic        ebus_drive;
  logic [0:35] ebus_data_out;
  logic [6:0]  ebus_pi;

  modport master (
    output ebus_cs, ebus_func, ebus_demand, ebus_data_in,
    input  ebus_xfer, ebus_drive, ebus_data_out, ebus_pi
  );

  modport slave (
    input  ebus_cs, ebus_func, ebus_demand, ebus_data_in,
    output ebus_xfer, ebus_drive, ebus_data_out, ebus_pi
  );

endinterface

// File: rtl/ebus_cono_reg.sv
// Device CONO register (PIA, ENA, BUSY, DONE) with set/clear priority and registered PI encode.
module ebus_cono_reg
  import ebus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cono_we,
  input  cono_cmd_t  cono_cmd,
  input  logic       clr_done,
  input  logic       dev_done,
  output logic [2:0] pia,
  output logic       ena,
  output logic       busy,
  output logic       done,
  output logic [6:0] pi
);

  logic done_clr;

  assign done_clr = clr_done | (cono_we & cono_cmd.clr_done);

  // A device completion is never lost: dev_done beats any same-cycle DONE clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pia  <= '0;
      ena  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pi   <= '0;
    end else begin
      if (cono_we) begin
        pia <= cono_cmd.pia;
        ena <= cono_cmd.ena;
        if (cono_cmd.clr_busy)      busy <= 1'b0;
        else if (cono_cmd.set_busy) busy <= 1'b1;
      end
      if (dev_done)      done <= 1'b1;
      else if (done_clr) done <= 1'b0;
      pi <= pi_encode(pia, ena & done);
    end
  end

endmodule

// File: rtl/ebus_io_responder.sv
// Generic EBUS device responder: decodes CS/function, answers demand with xfer after a
// programmable delay, drives CONI/DATAI data, commits CONO/DATAO and raises PI requests.
module ebus_io_responder
  import ebus_pkg::*;
#(
  parameter logic [6:0]  DEV_CS   = 7'o00,
  parameter int          XFER_DLY = 2,
  parameter logic [0:17] STAT_RO  = 18'h0
)(
  input  logic               clk,
  input  logic               reset,
  ebus_io_responder_if.slave bus,
  input  logic               dev_done,
  input  logic [0:35]        dev_rdata,
  output logic [0:35]        dev_wdata,
  output logic               dev_wstrobe
);

  localparam logic [3:0] DLY_LOAD = 4'(XFER_DLY - 1);

  resp_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  ebus_func_t  func_q;
  logic [0:35] data_q;
  logic        accept;
  logic        enter_xfer;
  logic        demand_ok;

  logic        xfer_q;
  logic        drive_q;
  logic [0:35] data_out_q;
  logic [0:35] wdata_q;
  logic        wstrobe_q;

  logic        cono_we;
  logic        datao_we;
  logic        datai_entry;
  cono_cmd_t   cono_cmd;
  logic [2:0]  pia;
  logic        ena;
  logic        busy;
  logic        done;
  logic [6:0]  pi;

  assign demand_ok = bus.ebus_demand && (bus.ebus_cs == DEV_CS) && is_dev_func(bus.ebus_func);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Dropping demand before xfer aborts the transfer without any commit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_xfer = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (demand_ok) begin
          state_d = ST_WAIT;
          cnt_d   = DLY_LOAD;
          accept  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!bus.ebus_demand) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d    = ST_XFER;
          enter_xfer = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_XFER: begin
        if (!bus.ebus_demand) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cono_we     = enter_xfer && (func_q == CONO);
  assign datao_we    = enter_xfer && (func_q == DATAO);
  assign datai_entry = enter_xfer && (func_q == DATAI);

  assign cono_cmd = '{
    pia:      data_q[CONO_PIA_MSB:CONO_PIA_LSB],
    ena:      data_q[CONO_ENA_BIT],
    clr_done: data_q[CONO_CLR_DONE_BIT],
    set_busy: data_q[CONO_SET_BUSY_BIT],
    clr_busy: data_q[CONO_CLR_BUSY_BIT]
  };

  ebus_cono_reg u_cono_reg (
    .clk      (clk),
    .reset    (reset),
    .cono_we  (cono_we),
    .cono_cmd (cono_cmd),
    .clr_done (datao_we | datai_entry),
    .dev_done (dev_done),
    .pia      (pia),
    .ena      (ena),
    .busy     (busy),
    .done     (done),
    .pi       (pi)
  );

  // Read data is captured once on XFER entry so the bus value cannot move while driven.
  always_ff @(posedge clk) begin
    if (reset) begin
      func_q     <= CONO;
      data_q     <= '0;
      xfer_q     <= 1'b0;
      drive_q    <= 1'b0;
      data_out_q <= '0;
      wdata_q    <= '0;
      wstrobe_q  <= 1'b0;
    end else begin
      if (accept) begin
        func_q <= bus.ebus_func;
        data_q <= bus.ebus_data_in;
      end
      xfer_q  <= (state_d == ST_XFER);
      drive_q <= (state_d == ST_XFER) && is_read_func(func_q);
      if (enter_xfer) begin
        if (func_q == DATAI)     data_out_q <= dev_rdata;
        else if (func_q == CONI) data_out_q <= coni_word(STAT_RO, busy, done, ena, pia);
        else                     data_out_q <= '0;
      end else if (state_d != ST_XFER) begin
        data_out_q <= '0;
      end
      wstrobe_q <= datao_we;
      if (datao_we) wdata_q <= data_q;
    end
  end

  assign bus.ebus_xfer     = xfer_q;
  assign bus.ebus_drive    = drive_q;
  assign bus.ebus_data_out = data_out_q;
  assign bus.ebus_pi       = pi;
  assign dev_wdata         = wdata_q;
  assign dev_wstrobe       = wstrobe_q;

endmodule

// File: tb/tb_ebus_io_responder.sv
// Randomized scoreboard bench for ebus_io_responder against a device-level reference model.
module tb_ebus_io_responder;
  import ebus_pkg::*;

  localparam logic [6:0]  DEV_CS   = 7'o42;
  localparam int          XFER_DLY = 2;
  localparam logic [0:17] STAT_RO  = 18'o123456;

  typedef struct {
    int          cycle;
    logic        rd;
    logic [0:35] data;
    string       name;
  } xfer_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        dev_done;
  logic [0:35] dev_rdata;
  logic [0:35] dev_wdata;
  logic        dev_wstrobe;

  ebus_io_responder_if bus();

  ebus_io_responder #(
    .DEV_CS   (DEV_CS),
    .XFER_DLY (XFER_DLY),
    .STAT_RO  (STAT_RO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dev_done    (dev_done),
    .dev_rdata   (dev_rdata),
    .dev_wdata   (dev_wdata),
    .dev_wstrobe (dev_wstrobe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  xfer_exp_t   xq[$];
  logic [0:35] wq[$];

  // Reference device state, updated at the transaction level.
  logic [2:0] m_pia  = '0;
  logic       m_ena  = 1'b0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  bit         in_release = 1'b0;

  task automatic checkOutput(input string name, input logic [35:0] actual, input logic [35:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0o, expected %0o (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [0:35] rand36();
    logic [0:35] r;
    r[0:3]  = 4'($urandom());
    r[4:35] = $urandom();
    return r;
  endfunction

  function automatic logic [0:35] model_coni();
    return {STAT_RO, 11'b0, m_busy, m_done, m_ena, 1'b0, m_pia};
  endfunction

  function automatic logic [6:0] model_pi();
    logic [6:0] r;
    r = '0;
    if (m_ena && m_done && (m_pia != 3'd0)) r = 7'(1 << (int'(m_pia) - 1));
    return r;
  endfunction

  function automatic string fname(input logic [2:0] f);
    case (f)
      3'o0:    return "cono";
      3'o1:    return "coni";
      3'o2:    return "datao";
      3'o3:    return "datai";
      default: return "rsvd";
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after demand is dropped.
  task automatic applyStimulus(input logic [6:0] cs, input logic [2:0] f, input logic [0:35] d,
                               input int hold, input bit done_at_entry);
    xfer_exp_t e;
    bit        responds;
    int        n;
    int        extra;
    responds = (cs == DEV_CS) && (f <= 3'o3);
    extra    = in_release ? 1 : 0;
    bus.ebus_cs      = cs;
    bus.ebus_func    = ebus_func_t'(f);
    bus.ebus_data_in = d;
    bus.ebus_demand  = 1'b1;
    if (responds) begin
      e.cycle = cyc + 1 + XFER_DLY + extra;
      e.rd    = (f == 3'o1) || (f == 3'o3);
      e.data  = (f == 3'o1) ? model_coni() : ((f == 3'o3) ? dev_rdata : 36'o0);
      e.name  = fname(f);
      xq.push_back(e);
      if (f == 3'o2) wq.push_back(d);
      if (done_at_entry) begin
        repeat (XFER_DLY + extra) @(negedge clk);
        dev_done = 1'b1;
        @(negedge clk);
        dev_done = 1'b0;
      end
      n = 0;
      while (!bus.ebus_xfer && n < XFER_DLY + 8) begin
        @(negedge clk);
        n++;
      end
      checkOutput({e.name, "_xfer_seen"}, 36'(bus.ebus_xfer), 36'(1));
      case (f)
        3'o0: begin
          m_pia = d[33:35];
          m_ena = d[32];
          if (d[23]) m_done = 1'b0;
          if (d[21])      m_busy = 1'b0;
          else if (d[22]) m_busy = 1'b1;
        end
        3'o2, 3'o3: m_done = 1'b0;
        default: ;
      endcase
      if (done_at_entry) m_done = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (f == 3'o3) dev_rdata = rand36();
      end
    end else begin
      repeat (XFER_DLY + 4) @(negedge clk);
    end
    bus.ebus_demand = 1'b0;
    @(negedge clk);
    in_release = responds;
  endtask

  task automatic pulseDone();
    dev_done = 1'b1;
    @(negedge clk);
    dev_done   = 1'b0;
    m_done     = 1'b1;
    in_release = 1'b0;
  endtask

  task automatic checkPi(input string name);
    repeat (2) @(negedge clk);
    in_release = 1'b0;
    checkOutput(name, 36'(bus.ebus_pi), 36'(model_pi()));
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents xfer or a write strobe.
  initial begin : monitor
    xfer_exp_t   cur;
    logic [0:35] w;
    bit          cur_valid    = 1'b0;
    logic        prev_xfer    = 1'b0;
    logic        prev_wstrobe = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ebus_xfer && !prev_xfer) begin
        checkOutput("xfer_expected", 36'(bus.ebus_xfer), 36'(xq.size() != 0));
        if (xq.size() != 0) begin
          cur       = xq.pop_front();
          cur_valid = 1'b1;
          checkOutput({cur.name, "_latency"}, 36'(cyc), 36'(cur.cycle));
        end
      end
      if (bus.ebus_xfer && cur_valid) begin
        checkOutput({cur.name, "_drive"}, 36'(bus.ebus_drive), 36'(cur.rd));
        checkOutput({cur.name, "_data_out"}, bus.ebus_data_out, cur.data);
      end
      if (!bus.ebus_xfer) begin
        cur_valid = 1'b0;
        checkOutput("idle_drive", 36'(bus.ebus_drive), 36'(0));
        checkOutput("idle_data_out", bus.ebus_data_out, 36'o0);
      end
      if (dev_wstrobe) begin
        checkOutput("wstrobe_expected", 36'(dev_wstrobe), 36'(wq.size() != 0));
        checkOutput("wstrobe_width", 36'(prev_wstrobe), 36'(0));
        checkOutput("wstrobe_timing", 36'(prev_xfer), 36'(0));
        if (wq.size() != 0) begin
          w = wq.pop_front();
          checkOutput("wdata", dev_wdata, w);
        end
      end
      prev_xfer    = bus.ebus_xfer;
      prev_wstrobe = dev_wstrobe;
    end
  end

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin : stimulus
    xfer_exp_t e;
    int        n;
    reset            = 1'b1;
    dev_done         = 1'b0;
    dev_rdata        = '0;
    bus.ebus_cs      = '0;
    bus.ebus_func    = CONO;
    bus.ebus_demand  = 1'b0;
    bus.ebus_data_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_xfer", 36'(bus.ebus_xfer), 36'(0));
    checkOutput("rst_drive", 36'(bus.ebus_drive), 36'(0));
    checkOutput("rst_data_out", bus.ebus_data_out, 36'o0);
    checkOutput("rst_pi", 36'(bus.ebus_pi), 36'(0));
    checkOutput("rst_wdata", dev_wdata, 36'o0);
    checkOutput("rst_wstrobe", 36'(dev_wstrobe), 36'(0));
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] CONO ENA=1 PIA=7 BUSY set, then dev_done");
    applyStimulus(DEV_CS, 3'o0, 36'o000000_020017, 1, 1'b0);
    @(negedge clk);
    in_release = 1'b0;
    dev_done = 1'b1;
    @(negedge clk);
    dev_done = 1'b0;
    m_done   = 1'b1;
    checkOutput("pi_lags_done", 36'(bus.ebus_pi), 36'(0));
    @(negedge clk);
    checkOutput("pi_ch7", 36'(bus.ebus_pi), 36'(7'b1000000));

    $display("[TB] CONI status word");
    applyStimulus(DEV_CS, 3'o1, 36'o0, 2, 1'b0);

    $display("[TB] DATAO commit");
    @(negedge clk);
    in_release = 1'b0;
    applyStimulus(DEV_CS, 3'o2, 36'o777000_000123, 0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("wdata_hold", dev_wdata, 36'o777000_000123);
    checkPi("pi_after_datao");

    $display("[TB] DATAI with dev_rdata moving during XFER");
    pulseDone();
    dev_rdata = rand36();
    applyStimulus(DEV_CS, 3'o3, rand36(), 3, 1'b0);
    checkPi("pi_after_datai");

    $display("[TB] abort in WAIT and foreign selects");
    pulseDone();
    bus.ebus_cs     = DEV_CS;
    bus.ebus_func   = DATAO;
    bus.ebus_data_in = rand36();
    bus.ebus_demand = 1'b1;
    @(negedge clk);
    bus.ebus_demand = 1'b0;
    repeat (XFER_DLY + 4) @(negedge clk);
    checkPi("pi_after_abort");
    applyStimulus(DEV_CS + 7'd1, 3'o1, 36'o0, 0, 1'b0);
    applyStimulus(DEV_CS, 3'o5, rand36(), 0, 1'b0);

    $display("[TB] back-to-back CONI through RELEASE");
    applyStimulus(DEV_CS, 3'o1, 36'o0, 0, 1'b0);
    applyStimulus(DEV_CS, 3'o1, 36'o0, 1, 1'b0);

    $display("[TB] dev_done races CONO DONE clear");
    @(negedge clk);
    in_release = 1'b0;
    applyStimulus(DEV_CS, 3'o0, 36'o000000_010013, 0, 1'b1);
    checkPi("pi_done_set_wins");

    $display("[TB] randomized transfers");
    for (int i = 0; i < 80; i++) begin
      logic [6:0] cs;
      logic [2:0] f;
      int         sel;
      sel = $urandom_range(0, 9);
      cs  = (sel == 0) ? (DEV_CS ^ 7'($urandom_range(1, 127))) : DEV_CS;
      f   = (sel == 1) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      dev_rdata = rand36();
      if ($urandom_range(0, 3) == 0) pulseDone();
      applyStimulus(cs, f, rand36(), $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 2) == 0) checkPi("pi_random");
    end
    checkPi("pi_random_end");

    $display("[TB] reset during XFER");
    applyStimulus(DEV_CS, 3'o0, 36'o000000_000015, 0, 1'b0);
    pulseDone();
    @(negedge clk);
    e.cycle = cyc + 1 + XFER_DLY;
    e.rd    = 1'b1;
    e.data  = model_coni();
    e.name  = "coni_rst";
    xq.push_back(e);
    bus.ebus_cs     = DEV_CS;
    bus.ebus_func   = CONI;
    bus.ebus_demand = 1'b1;
    n = 0;
    while (!bus.ebus_xfer && n < XFER_DLY + 8) begin
      @(negedge clk);
      n++;
    end
    checkOutput("coni_rst_xfer_seen", 36'(bus.ebus_xfer), 36'(1));
    reset           = 1'b1;
    bus.ebus_demand = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_xfer", 36'(bus.ebus_xfer), 36'(0));
    checkOutput("rst_mid_drive", 36'(bus.ebus_drive), 36'(0));
    checkOutput("rst_mid_data_out", bus.ebus_data_out, 36'o0);
    reset  = 1'b0;
    m_pia  = '0;
    m_ena  = 1'b0;
    m_busy = 1'b0;
    m_done = 1'b0;
    in_release = 1'b0;
    checkPi("pi_after_reset");
    applyStimulus(DEV_CS, 3'o1, 36'o0, 0, 1'b0);

    repeat (4) @(negedge clk);
    checkOutput("xq_drained", 36'(xq.size()), 36'(0));
    checkOutput("wq_drained", 36'(wq.size()), 36'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
